// File: rtl/data_mem_pkg.sv
// Shared widths and FSM state encoding for the data RAM front end.
package data_mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int CNT_W      = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_CAPT  = 3'd2,
      WR_ISSUE = 3'd3,
      RESP     = 3'd4
   } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Free-running debug counter: counts enabled cycles and wraps to zero on overflow.
module wrap_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_reg <= '0;
      end else if (i_en) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign o_count = count_reg;

endmodule

// File: rtl/data_mem_access.sv
// CPU-side request/response front end for the data RAM; MAR/MBR hold one
// transaction at a time and the FSM hides the RAM's registered read latency.
module data_mem_access
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_we,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_waddr,
   output logic [DATA_W-1:0] o_ram_wdata,
   output logic              o_ram_re,
   output logic [ADDR_W-1:0] o_ram_raddr,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic [CNT_W-1:0]  o_load_cnt,
   output logic [CNT_W-1:0]  o_store_cnt
);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] mar_reg;
   logic [DATA_W-1:0] mbr_reg;
   logic              we_reg;
   logic              accept;
   logic              rsp_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         mar_reg   <= '0;
         mbr_reg   <= '0;
         we_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            mar_reg <= i_req_addr;
            we_reg  <= i_req_we;
            if (i_req_we) begin
               mbr_reg <= i_req_wdata;
            end
         end else if (state_reg == RD_CAPT) begin
            mbr_reg <= i_ram_rdata;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_we    = 1'b0;
      o_ram_we    = 1'b0;
      o_ram_re    = 1'b0;
      accept      = 1'b0;
      rsp_done    = 1'b0;
      case (state_reg)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               accept     = 1'b1;
               state_next = i_req_we ? WR_ISSUE : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            o_ram_re   = 1'b1;
            state_next = RD_CAPT;
         end
         // RAM data for the read issued last cycle is valid now.
         RD_CAPT: begin
            state_next = RESP;
         end
         WR_ISSUE: begin
            o_ram_we   = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_we    = we_reg;
            if (i_rsp_ready) begin
               rsp_done   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Addresses and data always reflect MAR/MBR; only the strobes are state-gated.
   assign o_ram_waddr = mar_reg;
   assign o_ram_raddr = mar_reg;
   assign o_ram_wdata = mbr_reg;
   assign o_rsp_rdata = mbr_reg;

   wrap_counter #(.W(CNT_W)) u_load_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (rsp_done && !we_reg),
      .o_count (o_load_cnt)
   );

   wrap_counter #(.W(CNT_W)) u_store_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (rsp_done && we_reg),
      .o_count (o_store_cnt)
   );

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access with a behavioural 256x16 registered-read RAM.
module tb_data_mem_access;
   import data_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_we;
   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [15:0] ram_wdata;
   logic        ram_re;
   logic [7:0]  ram_raddr;
   logic [15:0] ram_rdata;
   logic [15:0] load_cnt;
   logic [15:0] store_cnt;

   logic [15:0] ram_mem [256];
   int          total = 0;
   int          bad = 0;
   int          overlap = 0;

   always #5 clk = ~clk;

   data_mem_access dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_rdata (rsp_rdata),
      .o_rsp_we    (rsp_we),
      .o_ram_we    (ram_we),
      .o_ram_waddr (ram_waddr),
      .o_ram_wdata (ram_wdata),
      .o_ram_re    (ram_re),
      .o_ram_raddr (ram_raddr),
      .i_ram_rdata (ram_rdata),
      .o_load_cnt  (load_cnt),
      .o_store_cnt (store_cnt)
   );

   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_raddr];
   end

   always @(negedge clk) begin
      if (ram_we && ram_re) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_counts", {load_cnt, store_cnt}, 0);
      chk("rst_strobes", {ram_we, ram_re}, 0);
      step();
      rst_n = 1'b1;

      // Store 0xBEEF -> 0x12
      step();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 16'hBEEF;
      step();
      $display("store addr=0x12 data=0xBEEF");
      req_valid = 1'b0;
      chk("st_we_k1", ram_we, 1);
      chk("st_waddr", ram_waddr, 8'h12);
      chk("st_wdata", ram_wdata, 16'hBEEF);
      chk("st_re_k1", ram_re, 0);
      chk("st_valid_k1", rsp_valid, 0);
      step();
      chk("st_valid_k2", rsp_valid, 1);
      chk("st_rsp_we", rsp_we, 1);
      chk("st_we_k2", ram_we, 0);
      step();
      chk("st_cnt", store_cnt, 1);
      chk("st_idle_ready", req_ready, 1);
      chk("st_valid_after", rsp_valid, 0);

      // Load 0x12
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
      step();
      $display("load addr=0x12");
      req_valid = 1'b0;
      chk("ld_re_k1", ram_re, 1);
      chk("ld_raddr", ram_raddr, 8'h12);
      chk("ld_valid_k1", rsp_valid, 0);
      step();
      chk("ld_re_k2", ram_re, 0);
      chk("ld_valid_k2", rsp_valid, 0);
      step();
      chk("ld_valid_k3", rsp_valid, 1);
      chk("ld_rdata", rsp_rdata, 16'hBEEF);
      chk("ld_rsp_we", rsp_we, 0);
      step();
      chk("ld_cnt", load_cnt, 1);
      chk("ld_st_cnt_same", store_cnt, 1);

      // Load with response stalled; a stray store request must be ignored
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
      step();
      req_we = 1'b1; req_addr = 8'h55; req_wdata = 16'h1234;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         $display("stall cycle %0d", i);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_rdata", rsp_rdata, 16'hBEEF);
         chk("stall_req_ready", req_ready, 0);
         chk("stall_strobes", {ram_we, ram_re}, 0);
         step();
      end
      chk("stall_mar_kept", ram_raddr, 8'h12);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("stall_ld_cnt", load_cnt, 2);
      chk("stall_st_cnt", store_cnt, 1);

      // Back-to-back store 0x0001 -> 0xFF then load 0xFF
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 16'h0001;
      step();
      $display("store addr=0xFF data=0x0001, then load addr=0xFF");
      req_we = 1'b0; req_wdata = 16'hAAAA;
      chk("b2b_st_waddr", ram_waddr, 8'hFF);
      chk("b2b_st_we", ram_we, 1);
      step();
      chk("b2b_st_resp", rsp_valid, 1);
      step();
      chk("b2b_idle", req_ready, 1);
      step();
      req_valid = 1'b0;
      chk("b2b_ld_re", ram_re, 1);
      chk("b2b_ld_raddr", ram_raddr, 8'hFF);
      step();
      step();
      chk("b2b_ld_valid", rsp_valid, 1);
      chk("b2b_ld_rdata", rsp_rdata, 16'h0001);
      step();
      chk("b2b_cnts", {load_cnt, store_cnt}, {16'd3, 16'd2});
      chk("no_overlap", overlap, 0);

      // Store counter wrap
      force dut.u_store_cnt.count_reg = 16'hFFFF;
      #1;
      release dut.u_store_cnt.count_reg;
      chk("wrap_preload", store_cnt, 16'hFFFF);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 16'h5A5A;
      step();
      $display("store addr=0x40 data=0x5A5A (counter wrap)");
      req_valid = 1'b0;
      step();
      step();
      chk("wrap_store_cnt", store_cnt, 16'h0000);
      chk("wrap_load_cnt", load_cnt, 3);

      // Async reset in RD_CAPT
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40;
      step();
      req_valid = 1'b0;
      step();
      chk("pre_rst_state", dut.state_reg, RD_CAPT);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset during RD_CAPT");
      chk("mid_rst_state", dut.state_reg, IDLE);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_mbr", rsp_rdata, 0);
      chk("mid_rst_mar", ram_raddr, 0);
      chk("mid_rst_counts", {load_cnt, store_cnt}, 0);
      chk("mid_rst_ready", req_ready, 1);
      step();
      rst_n = 1'b1;
      step();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
      step();
      $display("load addr=0xFF after reset");
      req_valid = 1'b0;
      chk("post_rst_re", ram_re, 1);
      step();
      step();
      chk("post_rst_valid", rsp_valid, 1);
      chk("post_rst_rdata", rsp_rdata, 16'h0001);
      step();
      chk("post_rst_ld_cnt", load_cnt, 1);
      chk("final_overlap", overlap, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
